// File: rtl/divider_pkg.sv
// ============================================================================
// Module : divider_pkg
// Brief  : Shared defaults and the single restoring-division step.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package divider_pkg;

  localparam int unsigned DIV_MAX_W = 32;
  localparam int unsigned DEF_N     = 8;
  localparam int unsigned DEF_M     = 4;
  localparam int unsigned DEF_TAG_W = 4;

  // Returns {quotient bit, new remainder} packed at bit position i_m and below.
  function automatic logic [DIV_MAX_W:0] restore_step(
    input logic [DIV_MAX_W:0] i_shifted,
    input logic [DIV_MAX_W:0] i_dvs,
    input int unsigned        i_m
  );
    logic                 ge;
    logic [DIV_MAX_W:0]   diff;
    ge   = (i_shifted >= i_dvs);
    diff = ge ? (i_shifted - i_dvs) : i_shifted;
    for (int unsigned b = 0; b <= DIV_MAX_W; b++) begin
      if (b >= i_m) diff[b] = 1'b0;
    end
    diff[i_m[5:0]] = ge;
    return diff;
  endfunction

endpackage

`default_nettype wire

// File: rtl/divider_pipe_if.sv
// ============================================================================
// Module : divider_pipe_if
// Brief  : Request/response handshake bundle for the pipelined divider.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface divider_pipe_if #(
  parameter int unsigned N     = 8,
  parameter int unsigned M     = 4,
  parameter int unsigned TAG_W = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     dividend;
  logic [M-1:0]     divisor;
  logic             is_signed;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     quotient;
  logic [M-1:0]     remainder;
  logic             div_zero;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, dividend, divisor, is_signed, in_tag, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero, out_tag
  );

  modport slave (
    input  in_valid, dividend, divisor, is_signed, in_tag, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero, out_tag
  );
endinterface

`default_nettype wire

// File: rtl/divider_stage.sv
// ============================================================================
// Module : divider_stage
// Brief  : One registered restoring step (one quotient bit) with hold enable.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module divider_stage
  import divider_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned M     = DEF_M,
  parameter int unsigned TAG_W = DEF_TAG_W
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_en,
  input  wire logic             i_valid,
  input  wire logic [M-1:0]     i_prem,
  input  wire logic [N-1:0]     i_quo,
  input  wire logic [N-1:0]     i_dvd,
  input  wire logic [M-1:0]     i_dvs,
  input  wire logic [M-1:0]     i_raw,
  input  wire logic [TAG_W-1:0] i_tag,
  input  wire logic             i_dbz,
  input  wire logic             i_sq,
  input  wire logic             i_sr,
  output logic                  o_valid,
  output logic [M-1:0]          o_prem,
  output logic [N-1:0]          o_quo,
  output logic [N-1:0]          o_dvd,
  output logic [M-1:0]          o_dvs,
  output logic [M-1:0]          o_raw,
  output logic [TAG_W-1:0]      o_tag,
  output logic                  o_dbz,
  output logic                  o_sq,
  output logic                  o_sr
);

  logic [M:0] w_shift;
  logic [M:0] w_step;

  assign w_shift = {i_prem, i_dvd[N-1]};
  assign w_step  = (M+1)'(restore_step((DIV_MAX_W+1)'(w_shift),
                                       (DIV_MAX_W+1)'(i_dvs), M));

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_prem  <= '0;
      o_quo   <= '0;
      o_dvd   <= '0;
      o_dvs   <= '0;
      o_raw   <= '0;
      o_tag   <= '0;
      o_dbz   <= 1'b0;
      o_sq    <= 1'b0;
      o_sr    <= 1'b0;
    end else if (i_en) begin
      o_valid <= i_valid;
      o_prem  <= w_step[M-1:0];
      o_quo   <= (i_quo << 1) | N'(w_step[M]);
      o_dvd   <= i_dvd << 1;
      o_dvs   <= i_dvs;
      o_raw   <= i_raw;
      o_tag   <= i_tag;
      o_dbz   <= i_dbz;
      o_sq    <= i_sq;
      o_sr    <= i_sr;
    end
  end

endmodule

`default_nettype wire

// File: rtl/divider_pipe.sv
// ============================================================================
// Module : divider_pipe
// Brief  : Fully pipelined restoring divider, one op per clock, whole-pipe stall.
//          Define DIVIDER_SIGNED_EN to honour is_signed (two's-complement ops).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module divider_pipe
  import divider_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned M     = DEF_M,
  parameter int unsigned TAG_W = DEF_TAG_W
) (
  input wire logic clk,
  input wire logic rst,
  divider_pipe_if.slave bus
);

  logic             w_stall;
  logic             w_valid [0:N];
  logic [M-1:0]     w_prem  [0:N];
  logic [N-1:0]     w_quo   [0:N];
  logic [N-1:0]     w_dvd   [0:N];
  logic [M-1:0]     w_dvs   [0:N];
  logic [M-1:0]     w_raw   [0:N];
  logic [TAG_W-1:0] w_tag   [0:N];
  logic             w_dbz   [0:N];
  logic             w_sq    [0:N];
  logic             w_sr    [0:N];
  logic [N-1:0]     w_q_fix;
  logic [M-1:0]     w_r_fix;

  logic             r_out_valid;
  logic [N-1:0]     r_quotient;
  logic [M-1:0]     r_remainder;
  logic             r_div_zero;
  logic [TAG_W-1:0] r_out_tag;

  assign w_stall      = r_out_valid && !bus.out_ready;
  assign bus.in_ready = !w_stall;

  assign w_valid[0] = bus.in_valid;
  assign w_prem[0]  = '0;
  assign w_quo[0]   = '0;
  assign w_raw[0]   = bus.dividend[M-1:0];
  assign w_tag[0]   = bus.in_tag;
  assign w_dbz[0]   = (bus.divisor == '0);

`ifdef DIVIDER_SIGNED_EN
  // Divide magnitudes; remember which results need negating at the end.
  logic w_neg_dvd;
  logic w_neg_dvs;
  assign w_neg_dvd = bus.is_signed & bus.dividend[N-1];
  assign w_neg_dvs = bus.is_signed & bus.divisor[M-1];
  assign w_dvd[0]  = w_neg_dvd ? -bus.dividend : bus.dividend;
  assign w_dvs[0]  = w_neg_dvs ? -bus.divisor  : bus.divisor;
  assign w_sq[0]   = w_neg_dvd ^ w_neg_dvs;
  assign w_sr[0]   = w_neg_dvd;
`else
  logic w_unused_signed;
  assign w_unused_signed = bus.is_signed;
  assign w_dvd[0]  = bus.dividend;
  assign w_dvs[0]  = bus.divisor;
  assign w_sq[0]   = 1'b0;
  assign w_sr[0]   = 1'b0;
`endif

  for (genvar i = 0; i < N; i++) begin : g_stage
    divider_stage #(.N(N), .M(M), .TAG_W(TAG_W)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_en    (!w_stall),
      .i_valid (w_valid[i]),
      .i_prem  (w_prem[i]),
      .i_quo   (w_quo[i]),
      .i_dvd   (w_dvd[i]),
      .i_dvs   (w_dvs[i]),
      .i_raw   (w_raw[i]),
      .i_tag   (w_tag[i]),
      .i_dbz   (w_dbz[i]),
      .i_sq    (w_sq[i]),
      .i_sr    (w_sr[i]),
      .o_valid (w_valid[i+1]),
      .o_prem  (w_prem[i+1]),
      .o_quo   (w_quo[i+1]),
      .o_dvd   (w_dvd[i+1]),
      .o_dvs   (w_dvs[i+1]),
      .o_raw   (w_raw[i+1]),
      .o_tag   (w_tag[i+1]),
      .o_dbz   (w_dbz[i+1]),
      .o_sq    (w_sq[i+1]),
      .o_sr    (w_sr[i+1])
    );
  end

  always_comb begin
    w_q_fix = w_quo[N];
    w_r_fix = w_prem[N];
`ifdef DIVIDER_SIGNED_EN
    if (w_sq[N]) w_q_fix = -w_quo[N];
    if (w_sr[N]) w_r_fix = -w_prem[N];
`endif
    // Divide-by-zero reports the raw dividend bits regardless of signedness.
    if (w_dbz[N]) begin
      w_q_fix = '1;
      w_r_fix = w_raw[N];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_div_zero  <= 1'b0;
      r_out_tag   <= '0;
    end else if (!w_stall) begin
      r_out_valid <= w_valid[N];
      r_quotient  <= w_valid[N] ? w_q_fix   : '0;
      r_remainder <= w_valid[N] ? w_r_fix   : '0;
      r_div_zero  <= w_valid[N] ? w_dbz[N]  : 1'b0;
      r_out_tag   <= w_valid[N] ? w_tag[N]  : '0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.quotient  = r_quotient;
  assign bus.remainder = r_remainder;
  assign bus.div_zero  = r_div_zero;
  assign bus.out_tag   = r_out_tag;

endmodule

`default_nettype wire

// File: tb/tb_divider_pipe.sv
// ============================================================================
// Module : tb_divider_pipe
// Brief  : Self-checking bench for divider_pipe (N=8, M=4, TAG_W=4).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_divider_pipe;

  localparam int N  = 8;
  localparam int M  = 4;
  localparam int TW = 4;

  typedef struct packed {
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    logic [3:0] t;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  divider_pipe_if #(.N(N), .M(M), .TAG_W(TW)) bus ();
  divider_pipe #(.N(N), .M(M), .TAG_W(TW)) dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t expq[$];
  int   n_vec      = 0;
  int   n_bad      = 0;
  int   ready_mode = 0;

  function automatic exp_t model(logic [7:0] a, logic [3:0] b, logic s, logic [3:0] t);
    exp_t e;
    int   sa;
    int   sb;
    e.t = t;
    e.z = 1'b0;
    sa  = $signed(a);
    sb  = $signed(b);
    if (b == 4'd0) begin
      e.q = 8'hFF;
      e.r = a[3:0];
      e.z = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
`ifdef DIVIDER_SIGNED_EN
      if (s) begin
        e.q = 8'(sa / sb);
        e.r = 4'(sa % sb);
      end
`else
      if (s && sa == sb) e.r = e.r;
`endif
    end
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t dut_out();
    exp_t c;
    c.q = bus.quotient;
    c.r = bus.remainder;
    c.z = bus.div_zero;
    c.t = bus.out_tag;
    return c;
  endfunction

  // Consumer side: out_ready changes 2 time units after each rising edge.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard: every transfer against the model, plus handshake and hold rules.
  initial begin
    logic prev_stall;
    exp_t prev_out;
    exp_t e;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        expq.delete();
        prev_stall = 1'b0;
      end else begin
        check("in_ready", 32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
        if (prev_stall) begin
          check("stall_hold", 32'(dut_out()), 32'(prev_out));
          check("stall_valid", 32'(bus.out_valid), 32'd1);
        end
        if (bus.in_valid && bus.in_ready)
          expq.push_back(model(bus.dividend, bus.divisor, bus.is_signed, bus.in_tag));
        if (bus.out_valid && bus.out_ready) begin
          if (expq.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_out: got tag %0h, required no result", bus.out_tag);
          end else begin
            e = expq.pop_front();
            check("result", 32'(dut_out()), 32'(e));
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_out   = dut_out();
      end
    end
  end

  task automatic wait_accept();
    bit ok;
    ok = 1'b0;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout: got in_ready 0, required 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_chk(logic [7:0] a, logic [3:0] b, logic s, logic [3:0] t,
                          logic [7:0] eq, logic [3:0] er, logic ez);
    int lat;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.is_signed = s;
    bus.in_tag    = t;
    bus.in_valid  = 1'b1;
    wait_accept();
    bus.in_valid  = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = c;
        break;
      end
    end
    check("latency", 32'(lat), 32'(N));
    check("quotient", 32'(bus.quotient), 32'(eq));
    check("remainder", 32'(bus.remainder), 32'(er));
    check("div_zero", 32'(bus.div_zero), 32'(ez));
    check("out_tag", 32'(bus.out_tag), 32'(t));
    @(posedge clk);
    #1;
  endtask

  task automatic stream(int cnt, bit rnd);
    for (int i = 0; i < cnt; i++) begin
      bus.dividend  = rnd ? 8'($urandom_range(0, 255)) : 8'(37 * i + 11);
      bus.divisor   = rnd ? 4'($urandom_range(0, 15))  : 4'(i + 1);
      bus.is_signed = rnd ? 1'($urandom_range(0, 1))   : 1'b0;
      bus.in_tag    = 4'(i);
      bus.in_valid  = 1'b1;
      wait_accept();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int w = 0; w < 1000; w++) begin
      @(negedge clk);
      if (expq.size() == 0 && !bus.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending, required 0", expq.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.is_signed = 1'b0;
    bus.in_tag    = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_outputs", 32'(dut_out()), 32'd0);
    @(posedge clk);
    #1;

    send_chk(8'd200, 4'd7,  1'b0, 4'd3,  8'd28,  4'd4, 1'b0);
    send_chk(8'd55,  4'd0,  1'b0, 4'd5,  8'd255, 4'd7, 1'b0 | 1'b1);
    send_chk(8'd156, 4'd9,  1'b0, 4'd6,  8'd17,  4'd3, 1'b0);
    send_chk(8'd255, 4'd1,  1'b0, 4'd9,  8'd255, 4'd0, 1'b0);
    send_chk(8'd5,   4'd15, 1'b0, 4'd10, 8'd0,   4'd5, 1'b0);
    send_chk(8'h83,  4'd0,  1'b1, 4'd11, 8'hFF,  4'd3, 1'b1);
`ifdef DIVIDER_SIGNED_EN
    send_chk(8'h9C,  4'd7,  1'b1, 4'd7,  8'hF2,  4'hE, 1'b0);
    send_chk(8'h80,  4'hF,  1'b1, 4'd8,  8'h80,  4'h0, 1'b0);
`else
    send_chk(8'h9C,  4'd7,  1'b1, 4'd7,  8'd22,  4'd2, 1'b0);
    send_chk(8'h80,  4'hF,  1'b1, 4'd8,  8'd8,   4'd8, 1'b0);
`endif

    // Fill the pipe against a blocked consumer, then drain.
    ready_mode = 2;
    @(posedge clk);
    #1;
    stream(9, 1'b0);
    bus.dividend = 8'd99;
    bus.divisor  = 4'd3;
    bus.in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall_no_accept", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    ready_mode   = 0;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      check("drain_valid", 32'(bus.out_valid), 32'd1);
    end
    @(negedge clk);
    check("drain_done", 32'(bus.out_valid), 32'd0);
    wait_drain();

    // Reset with ops in flight.
    stream(6, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_outputs", 32'(dut_out()), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      check("no_stale", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send_chk(8'd9, 4'd2, 1'b0, 4'd12, 8'd4, 4'd1, 1'b0);

    ready_mode = 1;
    stream(300, 1'b1);
    ready_mode = 0;
    wait_drain();
    check("queue_empty", 32'(expq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
